midi_note_rx: RTL and testbench

- Upstream stage of the MIDI/ADC note selector. Receives the raw 31250-baud MIDI serial line and parses Note On, Note Off and All-Notes-Off messages.
- Drives the held note number that feeds input_midi_note[6:0], plus gate and velocity.
- Contains an 8N1 UART receiver followed by a running-status message parser FSM.

---
 rtl/midi_note_rx.sv | 242 ++++++++++++++++++++++++
 tb/tb_midi_note_rx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_rx.sv
// MIDI note receiver: 8N1 UART on the raw MIDI line plus a running-status parser
// for Note On/Off and All-Notes-Off. Define MIDI_OMNI_EN to accept all 16 channels.
module midi_note_rx #(
    parameter int CLKS_PER_BIT = 1600,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic       a_clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       note_valid,
    output logic       framing_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [2:0] {
        P_NO_STATUS, P_WAIT_KEY, P_WAIT_VEL, P_WAIT_CC, P_WAIT_CCVAL, P_IGNORE
    } parse_state_t;

    logic         rx_meta_q, rx_sync_q;
    uart_state_t  u_state_q, u_state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         stop_wait_q, stop_wait_d;
    logic         byte_valid_s, frame_err_s;

    parse_state_t p_state_q, p_state_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   key_q, key_d;
    logic [6:0]   cc_q, cc_d;
    logic [6:0]   note_q, note_d;
    logic [6:0]   vel_q, vel_d;
    logic         gate_q, gate_d;
    logic         note_valid_q, note_valid_d;
    logic         framing_err_q, framing_err_d;
    logic         chan_ok_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= midi_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // UART next-state: mid-bit sampling; a low stop bit parks in STOP until the line recovers
    always_comb begin
        u_state_d    = u_state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        stop_wait_d  = stop_wait_q;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (u_state_q)
            U_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_sync_q) begin
                    u_state_d = U_START;
                end else begin
                    u_state_d = U_IDLE;
                end
            end
            U_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    bit_d = 3'd0;
                    if (rx_sync_q) begin
                        u_state_d = U_IDLE;
                    end else begin
                        u_state_d = U_DATA;
                    end
                end else begin
                    u_state_d = U_START;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        u_state_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    u_state_d = U_DATA;
                end
            end
            U_STOP: begin
                if (stop_wait_q) begin
                    cnt_d = 16'd0;
                    if (rx_sync_q) begin
                        stop_wait_d = 1'b0;
                        u_state_d   = U_IDLE;
                    end else begin
                        u_state_d = U_STOP;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_sync_q) begin
                        byte_valid_s = 1'b1;
                        u_state_d    = U_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end else begin
                    u_state_d = U_STOP;
                end
            end
            default: begin
                u_state_d   = U_IDLE;
                stop_wait_d = 1'b0;
            end
        endcase
    end

`ifdef MIDI_OMNI_EN
    assign chan_ok_s = 1'b1;
`else
    assign chan_ok_s = (shreg_q[3:0] == 4'(MIDI_CHANNEL));
`endif

    // Parser next-state and output updates, evaluated only for completed bytes
    always_comb begin
        p_state_d     = p_state_q;
        status_d      = status_q;
        key_d         = key_q;
        cc_d          = cc_q;
        note_d        = note_q;
        vel_d         = vel_q;
        gate_d        = gate_q;
        note_valid_d  = 1'b0;
        framing_err_d = frame_err_s;
        if (byte_valid_s) begin
            if (shreg_q >= 8'hF8) begin
                p_state_d = p_state_q;
            end else if (shreg_q >= 8'hF0) begin
                status_d  = 8'h00;
                p_state_d = P_IGNORE;
            end else if (shreg_q[7]) begin
                status_d = shreg_q;
                if (chan_ok_s && (shreg_q[7:4] == 4'h8 || shreg_q[7:4] == 4'h9)) begin
                    p_state_d = P_WAIT_KEY;
                end else if (chan_ok_s && shreg_q[7:4] == 4'hB) begin
                    p_state_d = P_WAIT_CC;
                end else begin
                    p_state_d = P_IGNORE;
                end
            end else begin
                case (p_state_q)
                    P_WAIT_KEY: begin
                        key_d     = shreg_q[6:0];
                        p_state_d = P_WAIT_VEL;
                    end
                    P_WAIT_VEL: begin
                        p_state_d = P_WAIT_KEY;
                        if (status_q[7:4] == 4'h9 && shreg_q[6:0] != 7'd0) begin
                            note_d       = key_q;
                            vel_d        = shreg_q[6:0];
                            gate_d       = 1'b1;
                            note_valid_d = 1'b1;
                        end else if (gate_q && key_q == note_q) begin
                            gate_d = 1'b0;
                        end else begin
                            gate_d = gate_q;
                        end
                    end
                    P_WAIT_CC: begin
                        cc_d      = shreg_q[6:0];
                        p_state_d = P_WAIT_CCVAL;
                    end
                    P_WAIT_CCVAL: begin
                        p_state_d = P_WAIT_CC;
                        if (cc_q == 7'd123) begin
                            gate_d = 1'b0;
                        end else begin
                            gate_d = gate_q;
                        end
                    end
                    default: begin
                        p_state_d = p_state_q;
                    end
                endcase
            end
        end else begin
            note_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            u_state_q     <= U_IDLE;
            cnt_q         <= 16'd0;
            bit_q         <= 3'd0;
            shreg_q       <= 8'h00;
            stop_wait_q   <= 1'b0;
            p_state_q     <= P_NO_STATUS;
            status_q      <= 8'h00;
            key_q         <= 7'd0;
            cc_q          <= 7'd0;
            note_q        <= 7'd0;
            vel_q         <= 7'd0;
            gate_q        <= 1'b0;
            note_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            u_state_q     <= u_state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shreg_q       <= shreg_d;
            stop_wait_q   <= stop_wait_d;
            p_state_q     <= p_state_d;
            status_q      <= status_d;
            key_q         <= key_d;
            cc_q          <= cc_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            gate_q        <= gate_d;
            note_valid_q  <= note_valid_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign note        = note_q;
    assign velocity    = vel_q;
    assign gate        = gate_q;
    assign note_valid  = note_valid_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// Self-checking bench for midi_note_rx: serialises MIDI bytes onto midi_rx and
// compares outputs against a message-level reference model.
module tb_midi_note_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       midi_rx;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       gate;
    logic       note_valid;
    logic       framing_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [7:0]  m_status;
    logic [7:0]  m_data[$];
    logic [6:0]  m_note, m_vel;
    logic        m_gate;
    logic [13:0] exp_q[$];

    int nv_count = 0;
    int fe_count = 0;
    int last_nv_cyc = 0;
    int stop_start_cyc = 0;
    logic nv_prev = 1'b0;
    logic fe_prev = 1'b0;

    midi_note_rx #(.CLKS_PER_BIT(CPB), .MIDI_CHANNEL(0)) dut (
        .a_clk(clk), .reset(reset), .midi_rx(midi_rx), .note(note),
        .velocity(velocity), .gate(gate), .note_valid(note_valid),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // pulse monitor: every note_valid must carry the next expected note/velocity
    initial begin
        forever begin
            @(negedge clk);
            if (note_valid) begin
                nv_count = nv_count + 1;
                last_nv_cyc = cyc;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL nv_unexpected: note=%h vel=%h, required no pulse", note, velocity);
                end else begin
                    if ({note, velocity} !== exp_q[0]) begin
                        errors = errors + 1;
                        $display("FAIL nv_payload: note/vel=%h/%h, required %h/%h",
                                 note, velocity, exp_q[0][13:7], exp_q[0][6:0]);
                    end
                    void'(exp_q.pop_front());
                end
                checks = checks + 1;
                if (nv_prev) begin
                    errors = errors + 1;
                    $display("FAIL nv_width: note_valid high 2+ cycles, required 1");
                end
            end
            if (framing_err) begin
                fe_count = fe_count + 1;
                checks = checks + 1;
                if (fe_prev) begin
                    errors = errors + 1;
                    $display("FAIL fe_width: framing_err high 2+ cycles, required 1");
                end
            end
            nv_prev = note_valid;
            fe_prev = framing_err;
        end
    end

    function automatic bit chan_accepted(input logic [7:0] st);
`ifdef MIDI_OMNI_EN
        return 1'b1;
`else
        return st[3:0] == 4'd0;
`endif
    endfunction

    function automatic void model_reset();
        m_status = 8'h00;
        m_data.delete();
        m_note = 7'd0;
        m_vel  = 7'd0;
        m_gate = 1'b0;
        exp_q.delete();
    endfunction

    // Message-level model: collect two data bytes under the running status, then act
    function automatic void model_byte(input logic [7:0] b);
        logic [6:0] k, v;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_status = 8'h00;
            m_data.delete();
            return;
        end
        if (b[7]) begin
            m_status = b;
            m_data.delete();
            return;
        end
        if (m_status == 8'h00 || !chan_accepted(m_status)) return;
        if (!(m_status[7:4] inside {4'h8, 4'h9, 4'hB})) return;
        m_data.push_back(b);
        if (m_data.size() < 2) return;
        k = m_data[0][6:0];
        v = m_data[1][6:0];
        m_data.delete();
        if (m_status[7:4] == 4'hB) begin
            if (k == 7'd123) m_gate = 1'b0;
        end else if (m_status[7:4] == 4'h9 && v != 7'd0) begin
            m_note = k;
            m_vel  = v;
            m_gate = 1'b1;
            exp_q.push_back({k, v});
        end else if (m_gate && k == m_note) begin
            m_gate = 1'b0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_tx(input logic [7:0] b, input logic stop_bit);
        midi_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            tick(CPB);
        end
        stop_start_cyc = cyc;
        midi_rx = stop_bit;
        tick(CPB);
        midi_rx = 1'b1;
        if (!stop_bit) tick(CPB);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        uart_tx(b, 1'b1);
    endtask

    task automatic test_reset();
        int nv0;
        reset = 1'b1;
        midi_rx = 1'b1;
        model_reset();
        tick(3);
        reset = 1'b0;
        tick(3);
        checks = checks + 1;
        if ({note, velocity, gate, note_valid, framing_err} !== 17'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: %h/%h/%b/%b/%b, required all zero",
                     note, velocity, gate, note_valid, framing_err);
        end
        // abort a byte partway through with reset
        midi_rx = 1'b0;
        tick(CPB);
        midi_rx = 1'b1;
        tick(2 * CPB);
        midi_rx = 1'b0;
        tick(CPB);
        reset = 1'b1;
        tick(2);
        midi_rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3 * CPB);
        checks = checks + 1;
        if ({note, velocity, gate} !== 15'd0 || nv_count != 0 || fe_count != 0) begin
            errors = errors + 1;
            $display("FAIL reset_abort: note=%h vel=%h gate=%b nv=%0d fe=%0d, required zeros",
                     note, velocity, gate, nv_count, fe_count);
        end
        nv0 = nv_count;
        send(8'h90); send(8'h3C); send(8'h64);
        tick(4);
        checks = checks + 1;
        if ({note, velocity, gate} !== {7'h3C, 7'h64, 1'b1} || nv_count - nv0 != 1) begin
            errors = errors + 1;
            $display("FAIL reset_first_note: note=%h vel=%h gate=%b pulses=%0d, required 3c/64/1/1",
                     note, velocity, gate, nv_count - nv0);
        end
        checks = checks + 1;
        if (last_nv_cyc - stop_start_cyc < 2 || last_nv_cyc - stop_start_cyc >= CPB) begin
            errors = errors + 1;
            $display("FAIL reset_latency: pulse %0d cycles into stop bit, required 2..%0d",
                     last_nv_cyc - stop_start_cyc, CPB - 1);
        end
    endtask

    task automatic test_running_status();
        int nv0;
        nv0 = nv_count;
        send(8'h90); send(8'h30); send(8'h40); send(8'h34);
        send(8'h50); send(8'h34); send(8'h00);
        tick(4);
        checks = checks + 1;
        if ({note, velocity, gate} !== {7'h34, 7'h50, 1'b0} || nv_count - nv0 != 2) begin
            errors = errors + 1;
            $display("FAIL running_status: note=%h vel=%h gate=%b pulses=%0d, required 34/50/0/2",
                     note, velocity, gate, nv_count - nv0);
        end
    endtask

    task automatic test_noteoff_mismatch();
        send(8'h90); send(8'h3C); send(8'h22);
        send(8'h80); send(8'h3D); send(8'h00);
        tick(4);
        checks = checks + 1;
        if (gate !== 1'b1 || note !== 7'h3C) begin
            errors = errors + 1;
            $display("FAIL noteoff_other_key: gate=%b note=%h, required 1/3c", gate, note);
        end
        send(8'h80); send(8'h3C); send(8'h00);
        tick(4);
        checks = checks + 1;
        if (gate !== 1'b0 || note !== 7'h3C || velocity !== 7'h22) begin
            errors = errors + 1;
            $display("FAIL noteoff_match: gate=%b note=%h vel=%h, required 0/3c/22", gate, note, velocity);
        end
    endtask

    task automatic test_channel_realtime();
        send(8'h91); send(8'h40); send(8'h7F);
        tick(4);
        checks = checks + 1;
        if ({note, velocity, gate} !== {m_note, m_vel, m_gate}) begin
            errors = errors + 1;
            $display("FAIL channel_filter: %h/%h/%b, required %h/%h/%b",
                     note, velocity, gate, m_note, m_vel, m_gate);
        end
        send(8'h90); send(8'h45); send(8'hF8); send(8'h70);
        tick(4);
        checks = checks + 1;
        if ({note, velocity, gate} !== {7'h45, 7'h70, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL realtime_midmsg: %h/%h/%b, required 45/70/1", note, velocity, gate);
        end
    endtask

    task automatic test_all_notes_off();
        int nv0;
        send(8'hB0); send(8'h7B); send(8'h00);
        tick(4);
        checks = checks + 1;
        if (gate !== 1'b0 || note !== 7'h45) begin
            errors = errors + 1;
            $display("FAIL all_notes_off: gate=%b note=%h, required 0/45", gate, note);
        end
        nv0 = nv_count;
        send(8'h90); send(8'h11); send(8'h12);
        send(8'hF0); send(8'h10); send(8'h20); send(8'h21); send(8'h22);
        tick(4);
        checks = checks + 1;
        if ({note, velocity, gate} !== {7'h11, 7'h12, 1'b1} || nv_count - nv0 != 1) begin
            errors = errors + 1;
            $display("FAIL sysex_ignore: %h/%h/%b pulses=%0d, required 11/12/1/1",
                     note, velocity, gate, nv_count - nv0);
        end
        send(8'h90); send(8'h22); send(8'h33);
        tick(4);
        checks = checks + 1;
        if ({note, velocity} !== {7'h22, 7'h33}) begin
            errors = errors + 1;
            $display("FAIL status_recover: %h/%h, required 22/33", note, velocity);
        end
    endtask

    task automatic test_framing_glitch();
        int fe0, nv0;
        fe0 = fe_count;
        nv0 = nv_count;
        uart_tx(8'h90, 1'b0);
        tick(4);
        checks = checks + 1;
        if (fe_count - fe0 != 1 || nv_count != nv0 || note !== 7'h22) begin
            errors = errors + 1;
            $display("FAIL framing: errs=%0d pulses=%0d note=%h, required 1/0/22",
                     fe_count - fe0, nv_count - nv0, note);
        end
        midi_rx = 1'b0;
        tick(4);
        midi_rx = 1'b1;
        tick(3 * CPB);
        send(8'h41); send(8'h42);
        tick(4);
        checks = checks + 1;
        if (fe_count - fe0 != 1 || {note, velocity} !== {7'h41, 7'h42} || nv_count - nv0 != 1) begin
            errors = errors + 1;
            $display("FAIL glitch: errs=%0d note=%h vel=%h pulses=%0d, required 1/41/42/1",
                     fe_count - fe0, note, velocity, nv_count - nv0);
        end
    endtask

    task automatic test_random();
        logic [7:0] st_tab[8];
        logic [7:0] key_tab[4];
        logic [7:0] b;
        st_tab  = '{8'h90, 8'h90, 8'h80, 8'hB0, 8'h91, 8'h9F, 8'hC0, 8'hF0};
        key_tab = '{8'h30, 8'h31, 8'h7B, 8'h00};
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(9, 0) < 6) send(st_tab[$urandom_range(7, 0)]);
            send(key_tab[$urandom_range(3, 0)]);
            if ($urandom_range(3, 0) == 0) send(8'hF8);
            b = 8'($urandom_range(127, 0));
            if ($urandom_range(3, 0) == 0) b = 8'h00;
            send(b);
            tick(4);
            checks = checks + 1;
            if ({note, velocity, gate} !== {m_note, m_vel, m_gate} || exp_q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL random_%0d: %h/%h/%b, required %h/%h/%b (pending %0d)",
                         n, note, velocity, gate, m_note, m_vel, m_gate, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_running_status();
        test_noteoff_mismatch();
        test_channel_realtime();
        test_all_notes_off();
        test_framing_glitch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
